engine_read_response_kernel: RTL and testbench

ENGINE_READ_RESPONSE_KERNEL -- requirements
Module: engine_read_response_kernel

---
 rtl/engine_read_response_kernel_pkg.sv | 39 +++
 rtl/engine_read_response_slot_array.sv | 73 +++++++
 rtl/engine_read_response_kernel.sv | 135 +++++++++++++
 tb/tb_engine_read_response_kernel.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/engine_read_response_kernel_pkg.sv
// Shared types for the engine read-response kernel: packet payload, memory
// read response, per-slot state and the kernel control state.
package engine_read_response_kernel_pkg;

    localparam int FIELD_CNT = 4;
    localparam int FIELD_W   = 32;
    // Response tag is sized for the largest supported reorder depth (32).
    localparam int RSP_TAG_W = 5;

    typedef enum logic [1:0] {
        SEQUENCE_INVALID = 2'd0,
        SEQUENCE_RUNNING = 2'd1,
        SEQUENCE_DONE    = 2'd2,
        SEQUENCE_ERROR   = 2'd3
    } sequence_state_t;

    typedef struct packed {
        logic [FIELD_CNT-1:0][1:0]         field_state;
        logic [FIELD_CNT-1:0][FIELD_W-1:0] field;
    } EnginePacketData;

    typedef struct packed {
        logic [RSP_TAG_W-1:0] tag;
        logic [FIELD_W-1:0]   data;
    } EngineReadResponse;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_PENDING = 2'd1,
        SLOT_DONE    = 2'd2
    } slot_state_t;

    typedef enum logic [1:0] {
        CTRL_RUN     = 2'd0,
        CTRL_DRAIN   = 2'd1,
        CTRL_DRAINED = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/engine_read_response_slot_array.sv
// Reorder slot storage: one allocate write port, one response write port,
// one free port and a combinational read port at the retire pointer.
// Held in flops rather than RAM because three ports touch a slot per cycle.
module engine_read_response_slot_array
    import engine_read_response_kernel_pkg::*;
#(
    parameter int ROB_DEPTH = 8,
    parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic               ap_clk,
    input  logic               areset,
    input  logic               alloc_en,
    input  logic [TAG_W-1:0]   alloc_idx,
    input  EnginePacketData    alloc_data,
    input  logic               rsp_en,
    input  logic [TAG_W-1:0]   rsp_idx,
    input  logic [FIELD_W-1:0] rsp_data,
    output logic               rsp_pending,
    input  logic               free_en,
    input  logic [TAG_W-1:0]   free_idx,
    input  logic [TAG_W-1:0]   rd_idx,
    output slot_state_t        rd_state,
    output EnginePacketData    rd_data
);

    slot_state_t     state_vec [ROB_DEPTH];
    EnginePacketData data_vec  [ROB_DEPTH];

    generate
        for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_slot
            slot_state_t     state_reg;
            EnginePacketData data_reg;
            logic            alloc_hit;
            logic            rsp_hit;
            logic            free_hit;

            assign alloc_hit = alloc_en && (alloc_idx == TAG_W'(gi));
            assign rsp_hit   = rsp_en && (rsp_idx == TAG_W'(gi)) && (state_reg == SLOT_PENDING);
            assign free_hit  = free_en && (free_idx == TAG_W'(gi));

            // Slot lifecycle: FREE -> PENDING on allocate, DONE on response, FREE on retire.
            always_ff @(posedge ap_clk) begin
                if (areset) begin
                    state_reg <= SLOT_FREE;
                end else if (alloc_hit) begin
                    state_reg <= SLOT_PENDING;
                end else if (rsp_hit) begin
                    state_reg <= SLOT_DONE;
                end else if (free_hit) begin
                    state_reg <= SLOT_FREE;
                end
            end

            // Payload capture on allocate; response fills only field 0.
            always_ff @(posedge ap_clk) begin
                if (alloc_hit) begin
                    data_reg <= alloc_data;
                end else if (rsp_hit) begin
                    data_reg.field[0]       <= rsp_data;
                    data_reg.field_state[0] <= SEQUENCE_RUNNING;
                end
            end

            assign state_vec[gi] = state_reg;
            assign data_vec[gi]  = data_reg;
        end
    endgenerate

    assign rsp_pending = rsp_en && (state_vec[rsp_idx] == SLOT_PENDING);
    assign rd_state    = state_vec[rd_idx];
    assign rd_data     = data_vec[rd_idx];

endmodule

// File: rtl/engine_read_response_kernel.sv
// Read-response reorder kernel: tags outgoing reads, fills field 0 from
// out-of-order memory responses and releases packets in request order.
module engine_read_response_kernel
    import engine_read_response_kernel_pkg::*;
#(
    parameter int ROB_DEPTH = 8,
    parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic              ap_clk,
    input  logic              areset,
    input  logic              req_in_valid,
    input  EnginePacketData   req_in,
    output logic              req_in_ready,
    output logic [TAG_W-1:0]  req_tag_out,
    input  logic              rsp_in_valid,
    input  EngineReadResponse rsp_in,
    output logic              result_out_valid,
    output EnginePacketData   result_out,
    input  logic              result_out_ready,
    input  logic              drain_in,
    output logic              drained_out,
    output logic              tag_error_out
);

    localparam int CNT_W = TAG_W + 1;

    logic [TAG_W-1:0] wr_ptr_reg;
    logic [TAG_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    ctrl_state_t      ctrl_reg;
    logic             result_valid_reg;
    EnginePacketData  result_reg;
    logic             tag_error_reg;

    logic             accept;
    logic             retire;
    logic             tag_in_range;
    logic             rsp_en;
    logic             rsp_pending;
    slot_state_t      head_state;
    EnginePacketData  head_data;

    // Tags beyond the configured depth can never name a live slot.
    assign tag_in_range = ({1'b0, rsp_in.tag} < (RSP_TAG_W + 1)'(ROB_DEPTH));
    assign rsp_en       = rsp_in_valid && tag_in_range;

    assign req_in_ready = !areset && (count_reg < CNT_W'(ROB_DEPTH)) && (ctrl_reg == CTRL_RUN);
    assign req_tag_out  = wr_ptr_reg;
    assign accept       = req_in_valid && req_in_ready;
    assign retire       = (head_state == SLOT_DONE) && (!result_valid_reg || result_out_ready);

    engine_read_response_slot_array #(
        .ROB_DEPTH (ROB_DEPTH),
        .TAG_W     (TAG_W)
    ) u_slots (
        .ap_clk      (ap_clk),
        .areset      (areset),
        .alloc_en    (accept),
        .alloc_idx   (wr_ptr_reg),
        .alloc_data  (req_in),
        .rsp_en      (rsp_en),
        .rsp_idx     (rsp_in.tag[TAG_W-1:0]),
        .rsp_data    (rsp_in.data),
        .rsp_pending (rsp_pending),
        .free_en     (retire),
        .free_idx    (rd_ptr_reg),
        .rd_idx      (rd_ptr_reg),
        .rd_state    (head_state),
        .rd_data     (head_data)
    );

    // Occupancy: allocate and retire in the same cycle cancel out.
    always_comb begin
        count_next = count_reg;
        case ({accept, retire})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointers, occupancy, in-order output register and sticky tag error.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            result_valid_reg <= 1'b0;
            result_reg       <= '0;
            tag_error_reg    <= 1'b0;
        end else begin
            count_reg <= count_next;
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (retire) begin
                rd_ptr_reg       <= rd_ptr_reg + 1'b1;
                result_reg       <= head_data;
                result_valid_reg <= 1'b1;
            end else if (result_out_ready) begin
                result_valid_reg <= 1'b0;
            end
            if (rsp_in_valid && !rsp_pending) begin
                tag_error_reg <= 1'b1;
            end
        end
    end

    // Control FSM: drain blocks new requests until every slot has left the output.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            ctrl_reg <= CTRL_RUN;
        end else begin
            case (ctrl_reg)
                CTRL_RUN: begin
                    if (drain_in) ctrl_reg <= CTRL_DRAIN;
                end
                CTRL_DRAIN: begin
                    if (count_reg == '0 && !result_valid_reg) ctrl_reg <= CTRL_DRAINED;
                end
                CTRL_DRAINED: begin
                    if (!drain_in) ctrl_reg <= CTRL_RUN;
                end
                default: ctrl_reg <= CTRL_RUN;
            endcase
        end
    end

    assign result_out_valid = result_valid_reg;
    assign result_out       = result_reg;
    assign drained_out      = (ctrl_reg == CTRL_DRAINED);
    assign tag_error_out    = tag_error_reg;

endmodule

// File: tb/tb_engine_read_response_kernel.sv
// Scoreboard bench for engine_read_response_kernel: issue/respond tasks push
// and fill expected packets; a negedge monitor compares every presented result.
module tb_engine_read_response_kernel;
    import engine_read_response_kernel_pkg::*;

    localparam int TAG_W = 3;

    logic              ap_clk = 1'b0;
    logic              areset = 1'b1;
    logic              req_in_valid = 1'b0;
    EnginePacketData   req_in = '0;
    logic              req_in_ready;
    logic [TAG_W-1:0]  req_tag_out;
    logic              rsp_in_valid = 1'b0;
    EngineReadResponse rsp_in = '0;
    logic              result_out_valid;
    EnginePacketData   result_out;
    logic              result_out_ready = 1'b1;
    logic              drain_in = 1'b0;
    logic              drained_out;
    logic              tag_error_out;

    engine_read_response_kernel #(.ROB_DEPTH(8), .TAG_W(TAG_W)) dut (
        .ap_clk           (ap_clk),
        .areset           (areset),
        .req_in_valid     (req_in_valid),
        .req_in           (req_in),
        .req_in_ready     (req_in_ready),
        .req_tag_out      (req_tag_out),
        .rsp_in_valid     (rsp_in_valid),
        .rsp_in           (rsp_in),
        .result_out_valid (result_out_valid),
        .result_out       (result_out),
        .result_out_ready (result_out_ready),
        .drain_in         (drain_in),
        .drained_out      (drained_out),
        .tag_error_out    (tag_error_out)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int              tag;
        logic            filled;
        EnginePacketData pkt;
    } exp_t;

    exp_t exp_q[$];
    int   pop_cyc[$];
    int   nedge  = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic samp();
        @(negedge ap_clk);
        #1;
    endtask

    function automatic EnginePacketData mk(input int f1);
        EnginePacketData p;
        p = '0;
        p.field[1]       = f1;
        p.field[2]       = f1 * 3;
        p.field_state[1] = 2'd2;
        p.field_state[3] = 2'd1;
        return p;
    endfunction

    // Monitor: compare every presented result against the head of the queue.
    always @(negedge ap_clk) begin
        nedge = nedge + 1;
        if (!areset && result_out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", result_out_valid, 0);
            end else begin
                chk("result_data", result_out, exp_q[0].pkt);
                if (result_out_ready) begin
                    $display("result: tag=%0d field0=0x%0h field1=%0d", exp_q[0].tag,
                             result_out.field[0], result_out.field[1]);
                    pop_cyc.push_back(nedge);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input EnginePacketData pkt, input int tag);
        exp_t e;
        step();
        req_in_valid = 1'b1;
        req_in       = pkt;
        samp();
        chk("req_ready", req_in_ready, 1);
        chk("req_tag", req_tag_out, tag);
        e.tag = tag; e.filled = 1'b0; e.pkt = pkt;
        exp_q.push_back(e);
        $display("issue: tag=%0d field1=%0d", tag, pkt.field[1]);
        step();
        req_in_valid = 1'b0;
    endtask

    task automatic respond(input int tag, input logic [31:0] data, input logic hit);
        step();
        rsp_in_valid = 1'b1;
        rsp_in.tag   = RSP_TAG_W'(tag);
        rsp_in.data  = data;
        if (hit) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].tag == tag && !exp_q[i].filled) begin
                    exp_t e;
                    e = exp_q[i];
                    e.pkt.field[0]       = data;
                    e.pkt.field_state[0] = 2'd1;
                    e.filled             = 1'b1;
                    exp_q[i]             = e;
                    break;
                end
            end
        end
        $display("respond: tag=%0d data=0x%0h", tag, data);
        step();
        rsp_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        req_in_valid = 1'b0;
        rsp_in_valid = 1'b0;
        drain_in = 1'b0;
        result_out_ready = 1'b1;
        step();
        step();
        samp();
        chk("ready_in_reset", req_in_ready, 0);
        exp_q.delete();
        step();
        areset = 1'b0;
        samp();
        chk("rst_ready", req_in_ready, 1);
        chk("rst_valid", result_out_valid, 0);
        chk("rst_result", result_out, 0);
        chk("rst_drained", drained_out, 0);
        chk("rst_tag_error", tag_error_out, 0);
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            samp();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        // In-order responses.
        do_reset();
        for (int i = 0; i < 3; i++) issue(mk(10 + i), i);
        respond(0, 32'hA, 1);
        respond(1, 32'hB, 1);
        respond(2, 32'hC, 1);
        wait_empty("inorder_drain");

        // Out-of-order responses: nothing leaves until the head completes.
        do_reset();
        for (int i = 0; i < 4; i++) issue(mk(20 + i), i);
        respond(3, 32'h33, 1);
        samp(); chk("ooo_hold3", result_out_valid, 0);
        respond(1, 32'h11, 1);
        samp(); chk("ooo_hold1", result_out_valid, 0);
        respond(2, 32'h22, 1);
        samp(); chk("ooo_hold2", result_out_valid, 0);
        pop_cyc.delete();
        respond(0, 32'h00, 1);
        samp(); chk("lat_before", result_out_valid, 0);
        samp(); chk("lat_after", result_out_valid, 1);
        wait_empty("ooo_drain");
        chk("ooo_pops", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4) chk("ooo_burst", pop_cyc[3] - pop_cyc[0], 3);

        // Full: eight outstanding, then one retire frees tag 0 again.
        do_reset();
        for (int i = 0; i < 8; i++) issue(mk(30 + i), i);
        samp(); chk("full_ready", req_in_ready, 0);
        respond(0, 32'h55, 1);
        samp(); chk("full_still", req_in_ready, 0);
        samp(); chk("full_freed", req_in_ready, 1);
        issue(mk(38), 0);
        for (int i = 1; i < 8; i++) respond(i, 32'h60 + i, 1);
        respond(0, 32'h77, 1);
        wait_empty("full_drain");

        // Backpressure: output stalls with two completed slots.
        do_reset();
        result_out_ready = 1'b0;
        issue(mk(40), 0);
        issue(mk(41), 1);
        respond(0, 32'h40, 1);
        respond(1, 32'h41, 1);
        for (int i = 0; i < 5; i++) begin
            samp();
            chk("bp_pending", exp_q.size(), 2);
            chk("bp_valid", result_out_valid, 1);
        end
        pop_cyc.delete();
        step();
        result_out_ready = 1'b1;
        wait_empty("bp_drain");
        chk("bp_pops", pop_cyc.size(), 2);
        if (pop_cyc.size() == 2) chk("bp_burst", pop_cyc[1] - pop_cyc[0], 1);

        // Error on a FREE tag, then drain with two outstanding.
        do_reset();
        respond(5, 32'hDEAD, 0);
        samp();
        chk("err_flag", tag_error_out, 1);
        chk("err_no_out", result_out_valid, 0);
        result_out_ready = 1'b0;
        issue(mk(50), 0);
        issue(mk(51), 1);
        respond(0, 32'h50, 1);
        respond(1, 32'h51, 1);
        step();
        drain_in = 1'b1;
        step();
        samp();
        chk("drain_ready", req_in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            samp();
            chk("drain_not_done", drained_out, 0);
        end
        step();
        result_out_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (!drained_out && n < 50) begin
                samp();
                n++;
            end
        end
        chk("drained", drained_out, 1);
        chk("drain_empty", exp_q.size(), 0);
        chk("err_sticky", tag_error_out, 1);
        step();
        drain_in = 1'b0;
        step();
        samp();
        chk("undrain_flag", drained_out, 0);
        chk("undrain_ready", req_in_ready, 1);

        // Reset mid-operation discards the slot; its late response is an error.
        do_reset();
        issue(mk(60), 0);
        do_reset();
        respond(0, 32'h99, 0);
        samp();
        chk("post_reset_err", tag_error_out, 1);
        chk("post_reset_no_out", result_out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
